// File: rtl/fp_types.sv
// Shared FP issue types: decoded operation flags, issue classes and writeback mux encoding.
package fp_types;

  typedef struct packed {
    logic fmadd;
    logic fmsub;
    logic fnmadd;
    logic fnmsub;
    logic fadd;
    logic fsub;
    logic fmul;
    logic fdiv;
    logic fsqrt;
    logic fsgnj;
    logic fminmax;
    logic fcmp;
    logic fclass;
    logic fmv;
    logic cvt;
  } fp_operation_type;

  localparam logic [1:0] FP_WB_MISC = 2'd0;
  localparam logic [1:0] FP_WB_FMA  = 2'd1;
  localparam logic [1:0] FP_WB_FDIV = 2'd2;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_FMA  = 2'd1,
    CLS_DIV  = 2'd2,
    CLS_MISC = 2'd3
  } fp_issue_class;

  // Decode should set a single flag; if not, FMA beats DIV beats MISC.
  function automatic fp_issue_class fp_classify(input fp_operation_type op);
    fp_issue_class cls;
    cls = CLS_NONE;
    if (op.fmadd || op.fmsub || op.fnmadd || op.fnmsub || op.fadd || op.fsub || op.fmul)
      cls = CLS_FMA;
    else if (op.fdiv || op.fsqrt)
      cls = CLS_DIV;
    else if (op.fsgnj || op.fminmax || op.fcmp || op.fclass || op.fmv || op.cvt)
      cls = CLS_MISC;
    return cls;
  endfunction

endpackage

// File: rtl/fp_wb_slot_sched.sv
// Writeback slot reservations plus matching tag/kind delay line; a push appears FMA_LAT (FMA) or 1 (misc)
// cycles later on mature_*. Never stalls itself: callers must only push when the *_free flag is set.
module fp_wb_slot_sched #(
  parameter int FMA_LAT = 3,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push_fma,
  input  logic             push_misc,
  input  logic [TAG_W-1:0] push_tag,
  output logic             fma_free,
  output logic             misc_free,
  output logic             mature_vld,
  output logic             mature_fma,
  output logic [TAG_W-1:0] mature_tag,
  output logic             any_busy
);

  logic [FMA_LAT:1]            slot_q, slot_d, slot_sh;
  logic [FMA_LAT:1]            kind_q, kind_d, kind_sh;
  logic [FMA_LAT:1][TAG_W-1:0] tag_q, tag_d, tag_sh;

  always_comb begin
    slot_sh = '0;
    kind_sh = '0;
    tag_sh  = '0;
    for (int k = 1; k < FMA_LAT; k++) begin
      slot_sh[k] = slot_q[k+1];
      kind_sh[k] = kind_q[k+1];
      tag_sh[k]  = tag_q[k+1];
    end

    fma_free  = !slot_sh[FMA_LAT];
    misc_free = !slot_sh[1];

    slot_d = slot_sh;
    kind_d = kind_sh;
    tag_d  = tag_sh;
    if (push_fma) begin
      slot_d[FMA_LAT] = 1'b1;
      kind_d[FMA_LAT] = 1'b1;
      tag_d[FMA_LAT]  = push_tag;
    end
    if (push_misc) begin
      slot_d[1] = 1'b1;
      kind_d[1] = 1'b0;
      tag_d[1]  = push_tag;
    end
    if (flush) begin
      slot_d = '0;
      kind_d = '0;
      tag_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      kind_q <= '0;
      tag_q  <= '0;
    end else begin
      slot_q <= slot_d;
      kind_q <= kind_d;
      tag_q  <= tag_d;
    end
  end

  assign mature_vld = slot_q[1];
  assign mature_fma = kind_q[1];
  assign mature_tag = tag_q[1];
  assign any_busy   = |slot_q;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FP issue/writeback scheduler: starts are same-cycle with accept; FMA wb after FMA_LAT, misc after 1, fdiv in first free slot.
// req_ready drops when the needed wb slot or divider is taken, during flush, and when a held fdiv result is starving.
module fpu_issue_ctrl
  import fp_types::*;
#(
  parameter int FMA_LAT = 3,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  fp_operation_type req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             fma_start,
  output logic             misc_start,
  output logic             fdiv_start,
  input  logic             fdiv_done,
  output logic             fdiv_ack,
  output logic             wb_valid,
  output logic [1:0]       wb_sel,
  output logic [TAG_W-1:0] wb_tag,
  output logic             busy
);

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_RUN   = 2'd1,
    DIV_HOLD  = 2'd2,
    DIV_DRAIN = 2'd3
  } div_state_e;

  div_state_e       div_state_q, div_state_d;
  logic [1:0]       hold_cnt_q, hold_cnt_d;
  logic [TAG_W-1:0] div_tag_q, div_tag_d;
  logic             en_q, en_d;

  fp_issue_class    req_cls;
  logic             rdy_raw, starve, accept;
  logic             push_fma, push_misc, div_win;
  logic             fma_free, misc_free, mature_vld, mature_fma, slot_busy;
  logic [TAG_W-1:0] mature_tag;

  // en_q keeps issue closed until the first clock edge after reset release.
  assign en_d = 1'b1;

  always_comb begin
    req_cls = fp_classify(req_op);
    starve  = (div_state_q == DIV_HOLD) && (hold_cnt_q >= 2'd2);
    unique case (req_cls)
      CLS_FMA:  rdy_raw = fma_free && !starve;
      CLS_MISC: rdy_raw = misc_free && !starve;
      CLS_DIV:  rdy_raw = (div_state_q == DIV_IDLE);
      default:  rdy_raw = 1'b1;
    endcase
    req_ready  = rdy_raw && en_q && !flush;
    accept     = req_valid && req_ready;
    push_fma   = accept && (req_cls == CLS_FMA);
    push_misc  = accept && (req_cls == CLS_MISC);
    fma_start  = push_fma;
    misc_start = push_misc;
    fdiv_start = accept && (req_cls == CLS_DIV);
  end

  fp_wb_slot_sched #(
    .FMA_LAT (FMA_LAT),
    .TAG_W   (TAG_W)
  ) u_slot_sched (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_fma   (push_fma),
    .push_misc  (push_misc),
    .push_tag   (req_tag),
    .fma_free   (fma_free),
    .misc_free  (misc_free),
    .mature_vld (mature_vld),
    .mature_fma (mature_fma),
    .mature_tag (mature_tag),
    .any_busy   (slot_busy)
  );

  always_comb begin
    div_state_d = div_state_q;
    hold_cnt_d  = hold_cnt_q;
    div_tag_d   = div_tag_q;
    div_win     = 1'b0;
    fdiv_ack    = 1'b0;
    unique case (div_state_q)
      DIV_IDLE: begin
        if (fdiv_start) begin
          div_tag_d   = req_tag;
          div_state_d = DIV_RUN;
        end
      end
      DIV_RUN: begin
        if (flush) begin
          div_state_d = DIV_DRAIN;
        end else if (fdiv_done) begin
          hold_cnt_d  = 2'd0;
          div_state_d = DIV_HOLD;
        end
      end
      DIV_HOLD: begin
        // A held result is discarded on flush but the divider still needs its ack.
        if (flush) begin
          fdiv_ack    = 1'b1;
          div_state_d = DIV_IDLE;
        end else if (!mature_vld) begin
          div_win     = 1'b1;
          fdiv_ack    = 1'b1;
          div_state_d = DIV_IDLE;
        end else if (hold_cnt_q != 2'd3) begin
          hold_cnt_d = hold_cnt_q + 2'd1;
        end
      end
      DIV_DRAIN: begin
        if (fdiv_done) begin
          fdiv_ack    = 1'b1;
          div_state_d = DIV_IDLE;
        end
      end
      default: div_state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_state_q <= DIV_IDLE;
      hold_cnt_q  <= '0;
      div_tag_q   <= '0;
      en_q        <= 1'b0;
    end else begin
      div_state_q <= div_state_d;
      hold_cnt_q  <= hold_cnt_d;
      div_tag_q   <= div_tag_d;
      en_q        <= en_d;
    end
  end

  always_comb begin
    wb_valid = mature_vld || div_win;
    wb_sel   = FP_WB_MISC;
    wb_tag   = '0;
    if (mature_vld) begin
      wb_sel = mature_fma ? FP_WB_FMA : FP_WB_MISC;
      wb_tag = mature_tag;
    end else if (div_win) begin
      wb_sel = FP_WB_FDIV;
      wb_tag = div_tag_q;
    end
  end

  assign busy = slot_busy || (div_state_q != DIV_IDLE);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl (FMA_LAT=3): inputs change 1ns after posedge, outputs checked before negedge.
module tb_fpu_issue_ctrl;
  import fp_types::*;

  logic             clk = 1'b0;
  logic             rst_n, flush, req_valid, req_ready;
  fp_operation_type req_op;
  logic [4:0]       req_tag, wb_tag;
  logic             fma_start, misc_start, fdiv_start, fdiv_done, fdiv_ack;
  logic             wb_valid, busy;
  logic [1:0]       wb_sel;

  int checks = 0;
  int failures = 0;

  fp_operation_type op_fmul, op_fadd, op_fsgnj, op_fdiv, op_fsqrt, op_none;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.FMA_LAT(3), .TAG_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_tag    (req_tag),
    .fma_start  (fma_start),
    .misc_start (misc_start),
    .fdiv_start (fdiv_start),
    .fdiv_done  (fdiv_done),
    .fdiv_ack   (fdiv_ack),
    .wb_valid   (wb_valid),
    .wb_sel     (wb_sel),
    .wb_tag     (wb_tag),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bench cycle: apply inputs just after the edge, return just before the next negedge.
  task automatic drive(input logic v, input fp_operation_type op, input logic [4:0] tag,
                       input logic done, input logic fl);
    @(posedge clk);
    #1;
    req_valid = v;
    req_op    = op;
    req_tag   = tag;
    fdiv_done = done;
    flush     = fl;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, op_none, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic chk_wb(input string tag, input logic v, input logic [1:0] sel, input logic [4:0] t);
    chk({tag, "_vld"}, 32'(wb_valid), 32'(v));
    if (v) begin
      chk({tag, "_sel"}, 32'(wb_sel), 32'(sel));
      chk({tag, "_tag"}, 32'(wb_tag), 32'(t));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    op_none  = '0;
    op_fmul  = '0; op_fmul.fmul   = 1'b1;
    op_fadd  = '0; op_fadd.fadd   = 1'b1;
    op_fsgnj = '0; op_fsgnj.fsgnj = 1'b1;
    op_fdiv  = '0; op_fdiv.fdiv   = 1'b1;
    op_fsqrt = '0; op_fsqrt.fsqrt = 1'b1;

    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = op_none; req_tag = '0; fdiv_done = 1'b0;
    #12;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_ack", 32'(fdiv_ack), 32'd0);
    #11 rst_n = 1'b1;
    idle(3);

    // FMA burst: 4 back-to-back fmul, writebacks in cycles 3..6.
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive(1'b1, op_fmul, 5'(c + 1), 1'b0, 1'b0);
      else       idle(1);
      if (c < 4) begin
        chk($sformatf("burst_ready_c%0d", c), 32'(req_ready), 32'd1);
        chk($sformatf("burst_start_c%0d", c), 32'(fma_start), 32'd1);
      end
      chk_wb($sformatf("burst_wb_c%0d", c), (c >= 3 && c <= 6), FP_WB_FMA, 5'(c - 2));
      chk($sformatf("burst_busy_c%0d", c), 32'(busy), 32'(c >= 1 && c <= 6));
    end

    // Collision: misc blocked where it would land on the fadd writeback.
    drive(1'b1, op_fadd, 5'd9, 1'b0, 1'b0);
    chk("coll_fadd_ready", 32'(req_ready), 32'd1);
    idle(1);
    drive(1'b1, op_fsgnj, 5'd10, 1'b0, 1'b0);
    chk("coll_misc_blocked", 32'(req_ready), 32'd0);
    chk("coll_misc_nostart", 32'(misc_start), 32'd0);
    drive(1'b1, op_fsgnj, 5'd10, 1'b0, 1'b0);
    chk("coll_misc_ready", 32'(req_ready), 32'd1);
    chk("coll_misc_start", 32'(misc_start), 32'd1);
    chk_wb("coll_fadd_wb", 1'b1, FP_WB_FMA, 5'd9);
    idle(1);
    chk_wb("coll_misc_wb", 1'b1, FP_WB_MISC, 5'd10);
    idle(1);
    chk("coll_busy_end", 32'(busy), 32'd0);

    // Divider arbitration against maturing FMA slots, plus anti-starvation.
    drive(1'b1, op_fdiv, 5'd7, 1'b0, 1'b0);
    chk("arb_fdiv_start", 32'(fdiv_start), 32'd1);
    drive(1'b1, op_fmul, 5'd11, 1'b0, 1'b0);
    chk("arb_fmul11_ready", 32'(req_ready), 32'd1);
    drive(1'b1, op_fmul, 5'd12, 1'b0, 1'b0);
    drive(1'b1, op_fmul, 5'd13, 1'b1, 1'b0);
    drive(1'b0, op_none, 5'd0, 1'b1, 1'b0);
    chk_wb("arb_wb_c4", 1'b1, FP_WB_FMA, 5'd11);
    chk("arb_ack_c4", 32'(fdiv_ack), 32'd0);
    drive(1'b0, op_none, 5'd0, 1'b1, 1'b0);
    chk_wb("arb_wb_c5", 1'b1, FP_WB_FMA, 5'd12);
    drive(1'b1, op_fmul, 5'd14, 1'b1, 1'b0);
    chk_wb("arb_wb_c6", 1'b1, FP_WB_FMA, 5'd13);
    chk("arb_starve_ready", 32'(req_ready), 32'd0);
    chk("arb_starve_nostart", 32'(fma_start), 32'd0);
    drive(1'b0, op_none, 5'd0, 1'b1, 1'b0);
    chk_wb("arb_wb_div", 1'b1, FP_WB_FDIV, 5'd7);
    chk("arb_ack_c7", 32'(fdiv_ack), 32'd1);
    idle(1);
    chk("arb_ack_c8", 32'(fdiv_ack), 32'd0);
    chk("arb_wb_c8", 32'(wb_valid), 32'd0);
    chk("arb_busy_c8", 32'(busy), 32'd0);

    // Divider back-pressure: second fsqrt waits for the first ack.
    drive(1'b1, op_fsqrt, 5'd3, 1'b0, 1'b0);
    chk("bp_first_start", 32'(fdiv_start), 32'd1);
    drive(1'b1, op_fsqrt, 5'd4, 1'b0, 1'b0);
    chk("bp_run_ready", 32'(req_ready), 32'd0);
    drive(1'b1, op_fsqrt, 5'd4, 1'b1, 1'b0);
    chk("bp_done_ready", 32'(req_ready), 32'd0);
    drive(1'b1, op_fsqrt, 5'd4, 1'b1, 1'b0);
    chk("bp_hold_ready", 32'(req_ready), 32'd0);
    chk("bp_hold_ack", 32'(fdiv_ack), 32'd1);
    chk_wb("bp_wb_first", 1'b1, FP_WB_FDIV, 5'd3);
    drive(1'b1, op_fsqrt, 5'd4, 1'b0, 1'b0);
    chk("bp_second_start", 32'(fdiv_start), 32'd1);
    drive(1'b0, op_none, 5'd0, 1'b1, 1'b0);
    drive(1'b0, op_none, 5'd0, 1'b1, 1'b0);
    chk_wb("bp_wb_second", 1'b1, FP_WB_FDIV, 5'd4);
    idle(1);

    // Flush with two FMAs in flight and the divider running.
    drive(1'b1, op_fdiv, 5'd5, 1'b0, 1'b0);
    drive(1'b1, op_fmul, 5'd20, 1'b0, 1'b0);
    drive(1'b1, op_fmul, 5'd21, 1'b0, 1'b0);
    drive(1'b1, op_fmul, 5'd22, 1'b0, 1'b1);
    chk("fl_ready", 32'(req_ready), 32'd0);
    chk("fl_nostart", 32'(fma_start), 32'd0);
    drive(1'b0, op_none, 5'd0, 1'b0, 1'b0);
    chk("fl_wb_c4", 32'(wb_valid), 32'd0);
    chk("fl_busy_drain", 32'(busy), 32'd1);
    drive(1'b0, op_none, 5'd0, 1'b1, 1'b0);
    chk("fl_wb_c5", 32'(wb_valid), 32'd0);
    chk("fl_drain_ack", 32'(fdiv_ack), 32'd1);
    idle(1);
    chk("fl_busy_end", 32'(busy), 32'd0);
    chk("fl_ack_end", 32'(fdiv_ack), 32'd0);

    // Asynchronous reset mid-burst with divider running.
    drive(1'b1, op_fdiv, 5'd6, 1'b0, 1'b0);
    drive(1'b1, op_fmul, 5'd1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_op = op_fmul; req_tag = 5'd2;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_fma_start", 32'(fma_start), 32'd0);
    chk("ar_ready", 32'(req_ready), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_wb_valid", 32'(wb_valid), 32'd0);
    chk("ar_wb_tag", 32'(wb_tag), 32'd0);
    chk("ar_ack", 32'(fdiv_ack), 32'd0);
    req_valid = 1'b0; req_op = op_none; req_tag = '0;
    #13 rst_n = 1'b1;
    idle(2);
    drive(1'b1, op_fdiv, 5'd9, 1'b0, 1'b0);
    chk("ar_post_ready", 32'(req_ready), 32'd1);
    chk("ar_post_start", 32'(fdiv_start), 32'd1);
    drive(1'b1, op_fsgnj, 5'd8, 1'b1, 1'b0);
    chk("ar_post_misc", 32'(misc_start), 32'd1);
    drive(1'b0, op_none, 5'd0, 1'b1, 1'b0);
    chk_wb("ar_post_misc_wb", 1'b1, FP_WB_MISC, 5'd8);
    chk("ar_post_noack", 32'(fdiv_ack), 32'd0);
    drive(1'b0, op_none, 5'd0, 1'b1, 1'b0);
    chk_wb("ar_post_div_wb", 1'b1, FP_WB_FDIV, 5'd9);
    chk("ar_post_ack", 32'(fdiv_ack), 32'd1);
    idle(1);
    chk("ar_post_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
